// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus: PC/incrementer loop, instruction memory, hazard/redirect inputs, IF/ID outputs.
// misalign_err exists only when MISALIGN_TRAP_EN is defined.
interface pc_fetch_ctrl_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] PC;
    logic [SIZE-1:0] PC_plus4;
    logic            imem_req;
    logic            imem_ready;
    logic [31:0]     imem_instr;
    logic            stall;
    logic            branch_taken;
    logic [SIZE-1:0] branch_target;
    logic            jump;
    logic [SIZE-1:0] jump_target;
    logic            ifid_valid;
    logic [31:0]     ifid_instr;
    logic [SIZE-1:0] ifid_pc4;
`ifdef MISALIGN_TRAP_EN
    logic            misalign_err;
`endif

    modport master (
`ifdef MISALIGN_TRAP_EN
        output misalign_err,
`endif
        output PC, imem_req, ifid_valid, ifid_instr, ifid_pc4,
        input  PC_plus4, imem_ready, imem_instr, stall,
               branch_taken, branch_target, jump, jump_target
    );

    modport slave (
`ifdef MISALIGN_TRAP_EN
        input  misalign_err,
`endif
        input  PC, imem_req, ifid_valid, ifid_instr, ifid_pc4,
        output PC_plus4, imem_ready, imem_instr, stall,
               branch_taken, branch_target, jump, jump_target
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns PC, issues imem requests, loads IF/ID, parks a stalled fetch in a skid buffer.
// Optional MISALIGN_TRAP_EN adds a sticky misalign_err flag for unaligned redirect targets.
module pc_fetch_ctrl #(
    parameter int              SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_ctrl_if.master      bus
);
    typedef enum logic [1:0] {START, FETCH, HOLD} state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] pc, pc_nxt;
    logic            v, v_nxt;
    logic [31:0]     instr, instr_nxt;
    logic [SIZE-1:0] pc4, pc4_nxt;
    logic [31:0]     sk_instr, sk_instr_nxt;
    logic [SIZE-1:0] sk_pc4, sk_pc4_nxt;
    logic            req;
    logic            redirect;
    logic [SIZE-1:0] target;

    assign redirect = (state != START) && (bus.jump || bus.branch_taken);
    assign target   = bus.jump ? bus.jump_target : bus.branch_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= START;
            pc       <= RESET_PC;
            v        <= 1'b0;
            instr    <= '0;
            pc4      <= '0;
            sk_instr <= '0;
            sk_pc4   <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            v        <= v_nxt;
            instr    <= instr_nxt;
            pc4      <= pc4_nxt;
            sk_instr <= sk_instr_nxt;
            sk_pc4   <= sk_pc4_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        v_nxt        = v;
        instr_nxt    = instr;
        pc4_nxt      = pc4;
        sk_instr_nxt = sk_instr;
        sk_pc4_nxt   = sk_pc4;
        req          = 1'b0;
        case (state)
            START: state_nxt = FETCH;
            FETCH: begin
                req = 1'b1;
                if (!bus.imem_ready) begin
                    // A stalled IF/ID keeps its valid bit; otherwise the bubble shows through.
                    if (!bus.stall) v_nxt = 1'b0;
                end else if (!bus.stall) begin
                    v_nxt     = 1'b1;
                    instr_nxt = bus.imem_instr;
                    pc4_nxt   = bus.PC_plus4;
                    pc_nxt    = bus.PC_plus4;
                end else begin
                    sk_instr_nxt = bus.imem_instr;
                    sk_pc4_nxt   = bus.PC_plus4;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (!bus.stall) begin
                    v_nxt        = 1'b1;
                    instr_nxt    = sk_instr;
                    pc4_nxt      = sk_pc4;
                    pc_nxt       = bus.PC_plus4;
                    sk_instr_nxt = '0;
                    sk_pc4_nxt   = '0;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = START;
        endcase
        // Redirect flushes everything and wins over stall and any same-cycle fetch.
        if (redirect) begin
            pc_nxt       = {target[SIZE-1:2], 2'b00};
            v_nxt        = 1'b0;
            sk_instr_nxt = '0;
            sk_pc4_nxt   = '0;
            state_nxt    = FETCH;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err <= 1'b0;
        else if (redirect && (|target[1:0]))    err <= 1'b1;
    end
    assign bus.misalign_err = err;
`endif

    assign bus.PC         = pc;
    assign bus.imem_req   = req;
    assign bus.ifid_valid = v;
    assign bus.ifid_instr = instr;
    assign bus.ifid_pc4   = pc4;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: scoreboard of IF/ID loads plus per-step PC/handshake checks.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t mon_e;
    logic        last_valid = 1'b0;
    logic [31:0] last_pc4 = '0;

    pc_fetch_ctrl_if #(.SIZE(32)) bus();

    pc_fetch_ctrl #(.SIZE(32), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic exp_t mk(input logic [31:0] a);
        exp_t e;
        e.instr = mem(a);
        e.pc4   = a + 32'd4;
        return e;
    endfunction

    // Incrementer and zero-latency instruction memory models
    assign bus.PC_plus4   = bus.PC + 32'd4;
    assign bus.imem_instr = mem(bus.PC);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A new IF/ID load is a valid register whose contents changed since last cycle.
    always @(negedge clk) begin
        if (rst_n && bus.ifid_valid && (!last_valid || bus.ifid_pc4 != last_pc4)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL unexpected_load: observed pc4 %h expected no load", bus.ifid_pc4);
            end else begin
                mon_e = q.pop_front();
                chk("sb_ifid_instr", bus.ifid_instr, mon_e.instr);
                chk("sb_ifid_pc4", bus.ifid_pc4, mon_e.pc4);
            end
        end
        last_valid <= rst_n && bus.ifid_valid;
        last_pc4   <= bus.ifid_pc4;
    end

    initial begin
        rst_n             = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        tick(); tick();
        chk("rst_pc", bus.PC, RST_PC);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus.ifid_valid}, 32'd0);
        chk("rst_instr", bus.ifid_instr, 32'd0);
        chk("rst_pc4", bus.ifid_pc4, 32'd0);

        // START cycle then streaming fetch
        rst_n = 1'b1;
        chk("start_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        chk("fetch_req", {31'b0, bus.imem_req}, 32'd1);
        chk("fetch_pc0", bus.PC, RST_PC);
        for (int i = 0; i < 4; i++) begin
            q.push_back(mk(RST_PC + 32'(4 * i)));
            tick();
            chk("stream_valid", {31'b0, bus.ifid_valid}, 32'd1);
            chk("stream_pc", bus.PC, RST_PC + 32'(4 * (i + 1)));
        end

        // Jump to 0xC, fetch it, then stall at PC=0x10
        bus.jump = 1'b1; bus.jump_target = 32'h0000_000C;
        tick();
        bus.jump = 1'b0;
        chk("jmp_pc", bus.PC, 32'h0000_000C);
        chk("jmp_flush", {31'b0, bus.ifid_valid}, 32'd0);
        q.push_back(mk(32'h0000_000C));
        tick();
        chk("pre_stall_pc", bus.PC, 32'h0000_0010);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
            chk("hold_pc", bus.PC, 32'h0000_0010);
            chk("hold_valid", {31'b0, bus.ifid_valid}, 32'd1);
            chk("hold_pc4", bus.ifid_pc4, 32'h0000_0010);
        end
        bus.stall = 1'b0;
        q.push_back(mk(32'h0000_0010));
        tick();
        chk("release_pc", bus.PC, 32'h0000_0014);
        chk("release_pc4", bus.ifid_pc4, 32'h0000_0014);
        chk("release_req", {31'b0, bus.imem_req}, 32'd1);
        q.push_back(mk(32'h0000_0014));
        tick();
        chk("after_release_pc", bus.PC, 32'h0000_0018);

        // Memory wait with and without stall
        bus.imem_ready = 1'b0;
        tick();
        chk("wait_valid", {31'b0, bus.ifid_valid}, 32'd0);
        chk("wait_pc", bus.PC, 32'h0000_0018);
        bus.imem_ready = 1'b1;
        q.push_back(mk(32'h0000_0018));
        tick();
        bus.imem_ready = 1'b0; bus.stall = 1'b1;
        tick();
        chk("wait_stall_valid", {31'b0, bus.ifid_valid}, 32'd1);
        chk("wait_stall_pc", bus.PC, 32'h0000_001C);
        chk("wait_stall_req", {31'b0, bus.imem_req}, 32'd1);
        bus.stall = 1'b0;
        tick();
        chk("wait_drop_valid", {31'b0, bus.ifid_valid}, 32'd0);

        // Jump beats branch
        bus.imem_ready = 1'b1;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0100;
        bus.jump = 1'b1;         bus.jump_target   = 32'h0000_0200;
        tick();
        bus.branch_taken = 1'b0; bus.jump = 1'b0;
        chk("prio_pc", bus.PC, 32'h0000_0200);
        chk("prio_valid", {31'b0, bus.ifid_valid}, 32'd0);
        q.push_back(mk(32'h0000_0200));
        tick();
        chk("prio_pc4", bus.ifid_pc4, 32'h0000_0204);

        // Branch during HOLD overrides stall and discards the skid
        bus.stall = 1'b1;
        tick();
        chk("hold2_req", {31'b0, bus.imem_req}, 32'd0);
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0080;
        tick();
        bus.branch_taken = 1'b0;
        chk("br_stall_pc", bus.PC, 32'h0000_0080);
        chk("br_stall_valid", {31'b0, bus.ifid_valid}, 32'd0);
        chk("br_stall_req", {31'b0, bus.imem_req}, 32'd1);
        bus.stall = 1'b0;
        q.push_back(mk(32'h0000_0080));
        tick();
        chk("br_next_pc", bus.PC, 32'h0000_0084);

        // Wrap at the top of the address space
        bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
        tick();
        bus.jump = 1'b0;
        chk("wrap_pc", bus.PC, 32'hFFFF_FFFC);
        q.push_back(mk(32'hFFFF_FFFC));
        tick();
        chk("wrap_next_pc", bus.PC, 32'h0000_0000);
        chk("wrap_pc4", bus.ifid_pc4, 32'h0000_0000);

        // Unaligned jump target
        bus.jump = 1'b1; bus.jump_target = 32'h0000_0103;
        tick();
        bus.jump = 1'b0;
        chk("misalign_pc", bus.PC, 32'h0000_0100);
`ifdef MISALIGN_TRAP_EN
        chk("misalign_err", {31'b0, bus.misalign_err}, 32'd1);
`endif
        q.push_back(mk(32'h0000_0100));
        tick();
`ifdef MISALIGN_TRAP_EN
        chk("misalign_sticky", {31'b0, bus.misalign_err}, 32'd1);
`endif

        // Asynchronous reset in the middle of a stall
        bus.stall = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", bus.PC, RST_PC);
        chk("arst_valid", {31'b0, bus.ifid_valid}, 32'd0);
        chk("arst_instr", bus.ifid_instr, 32'd0);
        chk("arst_pc4", bus.ifid_pc4, 32'd0);
        chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
`ifdef MISALIGN_TRAP_EN
        chk("arst_err", {31'b0, bus.misalign_err}, 32'd0);
`endif
        chk("sb_empty_mid", 32'(q.size()), 32'd0);

        // Redirect during START is ignored
        tick();
        bus.stall = 1'b0;
        rst_n = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 32'h0000_0300;
        tick();
        bus.jump = 1'b0;
        chk("start_redirect_pc", bus.PC, RST_PC);
        q.push_back(mk(RST_PC));
        tick();
        chk("restart_pc", bus.PC, RST_PC + 32'd4);
        tick();
        chk("sb_empty_end", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
